// File: rtl/axi_fault_reporter_if.sv
// AXI read/write handshake and response signals observed by the fault reporter.
// The reporter is a passive observer and connects through the monitor modport.
interface axi_fault_reporter_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic              rlast;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, bready, arvalid, araddr, rready,
        input  awready, bvalid, bresp, arready, rvalid, rlast, rresp
    );

    modport slave (
        input  awvalid, awaddr, bready, arvalid, araddr, rready,
        output awready, bvalid, bresp, arready, rvalid, rlast, rresp
    );

    modport monitor (
        input awvalid, awready, awaddr, bvalid, bready, bresp,
        input arvalid, arready, araddr, rvalid, rready, rlast, rresp
    );
endinterface

// File: rtl/axi_fault_reporter.sv
// Tracks one outstanding AXI read and write, detects error responses and timeouts,
// and reports the first fault over a valid/ready handshake with a saturating count.
module axi_fault_reporter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    axi_fault_reporter_if.monitor bus,
    output logic                 o_exc_valid,
    input  logic                 i_exc_ready,
    output logic [1:0]           o_exc_cause,
    output logic [ADDR_W-1:0]    o_exc_addr,
    output logic [1:0]           o_exc_resp,
    output logic [CNT_W-1:0]     o_fault_cnt,
    output logic                 o_overflow,
    input  logic                 i_clr
);
    localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT - 1);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StReport = 1'b1;

    logic              rd_busy_q, rd_busy_d, rd_faulted_q, rd_faulted_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [TmoW-1:0]   rd_tmo_q, rd_tmo_d;
    logic              wr_busy_q, wr_busy_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [TmoW-1:0]   wr_tmo_q, wr_tmo_d;

    logic [0:0]        state_q, state_d;
    logic [1:0]        cause_q, cause_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        resp_q, resp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic ar_hs, r_hs, r_last_hs, aw_hs, b_hs;
    logic ld_evt, st_evt, rd_tmo_evt, wr_tmo_evt;
    logic [2:0]         ev_cnt;
    logic               ovf_hit;
    logic [CNT_W-1:0]   cnt_base;
    logic [CNT_W+2:0]   cnt_sum;

    always_comb begin
        ar_hs     = bus.arvalid & bus.arready;
        r_hs      = bus.rvalid & bus.rready;
        r_last_hs = r_hs & bus.rlast;
        aw_hs     = bus.awvalid & bus.awready;
        b_hs      = bus.bvalid & bus.bready;

        ld_evt     = r_hs & (bus.rresp != 2'b00) & rd_busy_q & ~rd_faulted_q;
        st_evt     = b_hs & (bus.bresp != 2'b00) & wr_busy_q;
        rd_tmo_evt = rd_busy_q & (rd_tmo_q == TmoMax) & ~r_hs;
        wr_tmo_evt = wr_busy_q & (wr_tmo_q == TmoMax) & ~b_hs;
        ev_cnt     = 3'(ld_evt) + 3'(st_evt) + 3'(rd_tmo_evt) + 3'(wr_tmo_evt);
    end

    // A new address handshake wins over the closing beat of the previous transaction.
    always_comb begin
        rd_busy_d    = rd_busy_q;
        rd_addr_d    = rd_addr_q;
        rd_faulted_d = rd_faulted_q;
        rd_tmo_d     = rd_tmo_q;
        if (ar_hs && (!rd_busy_q || r_last_hs)) begin
            rd_busy_d    = 1'b1;
            rd_addr_d    = bus.araddr;
            rd_faulted_d = 1'b0;
            rd_tmo_d     = '0;
        end else if (rd_busy_q) begin
            if (r_last_hs || rd_tmo_evt) rd_busy_d = 1'b0;
            if (ld_evt) rd_faulted_d = 1'b1;
            rd_tmo_d = r_hs ? '0 : rd_tmo_q + 1'b1;
        end

        wr_busy_d = wr_busy_q;
        wr_addr_d = wr_addr_q;
        wr_tmo_d  = wr_tmo_q;
        if (aw_hs && (!wr_busy_q || b_hs)) begin
            wr_busy_d = 1'b1;
            wr_addr_d = bus.awaddr;
            wr_tmo_d  = '0;
        end else if (wr_busy_q) begin
            if (b_hs || wr_tmo_evt) wr_busy_d = 1'b0;
            wr_tmo_d = b_hs ? '0 : wr_tmo_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        addr_d  = addr_q;
        resp_d  = resp_q;
        ovf_hit = 1'b0;
        case (state_q)
            StIdle: begin
                if (ev_cnt != 3'd0) state_d = StReport;
                if (ld_evt) begin
                    cause_d = 2'b00;
                    addr_d  = rd_addr_q;
                    resp_d  = bus.rresp;
                end else if (st_evt) begin
                    cause_d = 2'b01;
                    addr_d  = wr_addr_q;
                    resp_d  = bus.bresp;
                end else if (rd_tmo_evt) begin
                    cause_d = 2'b10;
                    addr_d  = rd_addr_q;
                    resp_d  = 2'b00;
                end else if (wr_tmo_evt) begin
                    cause_d = 2'b11;
                    addr_d  = wr_addr_q;
                    resp_d  = 2'b00;
                end
                ovf_hit = (ev_cnt > 3'd1);
            end
            default: begin
                if (i_exc_ready) state_d = StIdle;
                ovf_hit = (ev_cnt != 3'd0);
            end
        endcase

        // Clear acts before this cycle's events are accumulated.
        cnt_base = i_clr ? '0 : cnt_q;
        cnt_sum  = {3'b000, cnt_base} + {{CNT_W{1'b0}}, ev_cnt};
        cnt_d    = (cnt_sum > {3'b000, {CNT_W{1'b1}}}) ? '1 : cnt_sum[CNT_W-1:0];
        ovf_d    = (ovf_q & ~i_clr) | ovf_hit;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_busy_q    <= 1'b0;
            rd_addr_q    <= '0;
            rd_faulted_q <= 1'b0;
            rd_tmo_q     <= '0;
            wr_busy_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_tmo_q     <= '0;
            state_q      <= StIdle;
            cause_q      <= 2'b00;
            addr_q       <= '0;
            resp_q       <= 2'b00;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            rd_busy_q    <= rd_busy_d;
            rd_addr_q    <= rd_addr_d;
            rd_faulted_q <= rd_faulted_d;
            rd_tmo_q     <= rd_tmo_d;
            wr_busy_q    <= wr_busy_d;
            wr_addr_q    <= wr_addr_d;
            wr_tmo_q     <= wr_tmo_d;
            state_q      <= state_d;
            cause_q      <= cause_d;
            addr_q       <= addr_d;
            resp_q       <= resp_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign o_exc_valid = (state_q == StReport);
    assign o_exc_cause = cause_q;
    assign o_exc_addr  = addr_q;
    assign o_exc_resp  = resp_q;
    assign o_fault_cnt = cnt_q;
    assign o_overflow  = ovf_q;
endmodule

// File: tb/tb_axi_fault_reporter.sv
// Directed bench for axi_fault_reporter with TIMEOUT=16 and CNT_W=8.
module tb_axi_fault_reporter;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 8;

    logic              i_clk;
    logic              i_rst;
    logic              o_exc_valid;
    logic              i_exc_ready;
    logic [1:0]        o_exc_cause;
    logic [ADDR_W-1:0] o_exc_addr;
    logic [1:0]        o_exc_resp;
    logic [CNT_W-1:0]  o_fault_cnt;
    logic              o_overflow;
    logic              i_clr;

    int n_checks = 0;
    int n_fail   = 0;

    axi_fault_reporter_if #(.ADDR_W(ADDR_W)) bus ();

    axi_fault_reporter #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .bus        (bus),
        .o_exc_valid(o_exc_valid),
        .i_exc_ready(i_exc_ready),
        .o_exc_cause(o_exc_cause),
        .o_exc_addr (o_exc_addr),
        .o_exc_resp (o_exc_resp),
        .o_fault_cnt(o_fault_cnt),
        .o_overflow (o_overflow),
        .i_clr      (i_clr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_ar(input logic [ADDR_W-1:0] a);
        bus.arvalid = 1'b1;
        bus.araddr  = a;
        step();
        bus.arvalid = 1'b0;
    endtask

    task automatic do_aw(input logic [ADDR_W-1:0] a);
        bus.awvalid = 1'b1;
        bus.awaddr  = a;
        step();
        bus.awvalid = 1'b0;
    endtask

    task automatic do_r(input logic [1:0] resp, input logic last);
        bus.rvalid = 1'b1;
        bus.rresp  = resp;
        bus.rlast  = last;
        step();
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
    endtask

    task automatic do_b(input logic [1:0] resp);
        bus.bvalid = 1'b1;
        bus.bresp  = resp;
        step();
        bus.bvalid = 1'b0;
    endtask

    initial begin
        i_rst       = 1'b1;
        i_exc_ready = 1'b0;
        i_clr       = 1'b0;
        bus.awvalid = 1'b0; bus.awready = 1'b1; bus.awaddr = '0;
        bus.bvalid  = 1'b0; bus.bready  = 1'b1; bus.bresp  = 2'b00;
        bus.arvalid = 1'b0; bus.arready = 1'b1; bus.araddr = '0;
        bus.rvalid  = 1'b0; bus.rready  = 1'b1; bus.rlast  = 1'b0; bus.rresp = 2'b00;

        step();
        step();
        chk("rst_valid", o_exc_valid, 0);
        chk("rst_cause", o_exc_cause, 0);
        chk("rst_addr", o_exc_addr, 0);
        chk("rst_resp", o_exc_resp, 0);
        chk("rst_cnt", o_fault_cnt, 0);
        chk("rst_ovf", o_overflow, 0);
        i_rst = 1'b0;
        step();

        // Load fault on a single-beat read
        do_ar(32'h8000_0010);
        chk("ld_pre_valid", o_exc_valid, 0);
        do_r(2'b10, 1'b1);
        chk("ld_valid", o_exc_valid, 1);
        chk("ld_cause", o_exc_cause, 2'b00);
        chk("ld_addr", o_exc_addr, 32'h8000_0010);
        chk("ld_resp", o_exc_resp, 2'b10);
        chk("ld_cnt", o_fault_cnt, 1);
        chk("ld_ovf", o_overflow, 0);
        i_exc_ready = 1'b1;
        step();
        i_exc_ready = 1'b0;
        chk("ld_ack_valid", o_exc_valid, 0);

        // Store fault, report held while ready is low
        do_aw(32'h1000_0000);
        do_b(2'b11);
        for (int i = 0; i < 5; i++) begin
            chk("st_hold_valid", o_exc_valid, 1);
            chk("st_hold_cause", o_exc_cause, 2'b01);
            chk("st_hold_addr", o_exc_addr, 32'h1000_0000);
            chk("st_hold_resp", o_exc_resp, 2'b11);
            step();
        end
        chk("st_cnt", o_fault_cnt, 2);
        i_exc_ready = 1'b1;
        step();
        i_exc_ready = 1'b0;
        chk("st_ack_valid", o_exc_valid, 0);

        // Read timeout: AR at edge N, event at N+16
        do_ar(32'h2000_0000);
        repeat (15) step();
        chk("tmo_early_valid", o_exc_valid, 0);
        step();
        chk("tmo_valid", o_exc_valid, 1);
        chk("tmo_cause", o_exc_cause, 2'b10);
        chk("tmo_addr", o_exc_addr, 32'h2000_0000);
        chk("tmo_resp", o_exc_resp, 2'b00);
        chk("tmo_cnt", o_fault_cnt, 3);
        i_exc_ready = 1'b1;
        step();
        i_exc_ready = 1'b0;

        // Response exactly at N+16 is on time
        do_ar(32'h2000_0040);
        repeat (15) step();
        do_r(2'b00, 1'b1);
        chk("ontime_valid", o_exc_valid, 0);
        repeat (3) step();
        chk("ontime_valid_late", o_exc_valid, 0);
        chk("ontime_cnt", o_fault_cnt, 3);

        // Clear, then simultaneous load and store faults
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        chk("clr_cnt", o_fault_cnt, 0);
        bus.arvalid = 1'b1; bus.araddr = 32'h3000_0100;
        bus.awvalid = 1'b1; bus.awaddr = 32'h3000_0200;
        step();
        bus.arvalid = 1'b0; bus.awvalid = 1'b0;
        bus.rvalid = 1'b1; bus.rresp = 2'b10; bus.rlast = 1'b1;
        bus.bvalid = 1'b1; bus.bresp = 2'b10;
        step();
        bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.bvalid = 1'b0;
        chk("dual_cause", o_exc_cause, 2'b00);
        chk("dual_addr", o_exc_addr, 32'h3000_0100);
        chk("dual_cnt", o_fault_cnt, 2);
        chk("dual_ovf", o_overflow, 1);
        i_exc_ready = 1'b1;
        i_clr = 1'b1;
        step();
        i_exc_ready = 1'b0;
        i_clr = 1'b0;
        chk("dual_clr_cnt", o_fault_cnt, 0);
        chk("dual_clr_ovf", o_overflow, 0);
        chk("dual_clr_valid", o_exc_valid, 0);

        // Burst with errors on beats 1 and 3 gives one event
        do_ar(32'h4000_0000);
        do_r(2'b00, 1'b0);
        do_r(2'b10, 1'b0);
        chk("burst_valid", o_exc_valid, 1);
        do_r(2'b00, 1'b0);
        do_r(2'b11, 1'b1);
        chk("burst_cnt", o_fault_cnt, 1);
        chk("burst_ovf", o_overflow, 0);
        chk("burst_resp", o_exc_resp, 2'b10);
        i_exc_ready = 1'b1;
        step();

        // Saturation with ready held high
        for (int k = 0; k < 300; k++) begin
            do_ar(32'h5000_0000);
            do_r(2'b10, 1'b1);
            if (k == 252) chk("sat_254", o_fault_cnt, 254);
        end
        chk("sat_cnt", o_fault_cnt, 255);
        chk("sat_ovf", o_overflow, 0);
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        i_exc_ready = 1'b0;
        chk("sat_clr_cnt", o_fault_cnt, 0);
        chk("sat_clr_valid", o_exc_valid, 0);

        // Asynchronous reset while reporting, mid-burst
        do_ar(32'h6000_0000);
        do_r(2'b10, 1'b0);
        chk("prerst_valid", o_exc_valid, 1);
        #1 i_rst = 1'b1;
        #1;
        chk("arst_valid", o_exc_valid, 0);
        chk("arst_cause", o_exc_cause, 0);
        chk("arst_addr", o_exc_addr, 0);
        chk("arst_resp", o_exc_resp, 0);
        chk("arst_cnt", o_fault_cnt, 0);
        chk("arst_ovf", o_overflow, 0);
        step();
        i_rst = 1'b0;
        step();
        do_r(2'b10, 1'b1);
        chk("stale_valid", o_exc_valid, 0);
        chk("stale_cnt", o_fault_cnt, 0);
        do_ar(32'h7000_0000);
        do_r(2'b00, 1'b1);
        chk("clean_valid", o_exc_valid, 0);
        chk("clean_cnt", o_fault_cnt, 0);
        chk("clean_ovf", o_overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
